// File: rtl/dispatcher_pkg.sv
// Shared widths, opcode encodings, the issue-register layout and state encoding
// for the dispatch stage.
package dispatcher_pkg;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int OP_W  = 6;

    // Tag 0 is reserved to mean "operand already has its value".
    localparam logic [TAG_W-1:0] NO_DEP = '0;

    localparam logic [OP_W-1:0] OP_NOP   = 6'd0;
    localparam logic [OP_W-1:0] OP_ADD   = 6'd1;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd2;
    localparam logic [OP_W-1:0] OP_LW    = 6'd3;
    localparam logic [OP_W-1:0] OP_SW    = 6'd4;
    localparam logic [OP_W-1:0] OP_FENCE = 6'd5;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } disp_state_e;

    typedef struct packed {
        logic             is_ls;
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] qi;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] dest;
        logic [XLEN-1:0]  vi;
        logic [XLEN-1:0]  vj;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
    } issue_t;

    function automatic logic cdb_hit(input logic             valid,
                                     input logic [TAG_W-1:0] cdb_tag,
                                     input logic [TAG_W-1:0] q);
        return valid && (q != NO_DEP) && (cdb_tag == q);
    endfunction
endpackage

// File: rtl/dispatcher_operand_resolve.sv
// Picks the value/tag of one source operand at dispatch time:
// unused/x0, RF value, ALU CDB, LSB CDB, ROB ready value, else wait on RF tag.
module dispatcher_operand_resolve
    import dispatcher_pkg::*;
(
    input  logic             use_i,
    input  logic [4:0]       rs_i,
    input  logic [TAG_W-1:0] rf_q_i,
    input  logic [XLEN-1:0]  rf_v_i,
    input  logic             alu_valid_i,
    input  logic [TAG_W-1:0] alu_tag_i,
    input  logic [XLEN-1:0]  alu_data_i,
    input  logic             lsb_valid_i,
    input  logic [TAG_W-1:0] lsb_tag_i,
    input  logic [XLEN-1:0]  lsb_data_i,
    input  logic             rob_ready_i,
    input  logic [XLEN-1:0]  rob_data_i,
    output logic [TAG_W-1:0] q_o,
    output logic [XLEN-1:0]  v_o
);
    always_comb begin
        q_o = NO_DEP;
        v_o = '0;
        if (use_i && rs_i != 5'd0) begin
            if (rf_q_i == NO_DEP) begin
                v_o = rf_v_i;
            end else if (cdb_hit(alu_valid_i, alu_tag_i, rf_q_i)) begin
                v_o = alu_data_i;
            end else if (cdb_hit(lsb_valid_i, lsb_tag_i, rf_q_i)) begin
                v_o = lsb_data_i;
            end else if (rob_ready_i) begin
                v_o = rob_data_i;
            end else begin
                q_o = rf_q_i;
            end
        end
    end
endmodule

// File: rtl/dispatcher.sv
// Dispatch stage: renames the IQ head into the ROB/RF and issues it to RS or LSB
// one cycle later. Valid/ready: an instruction moves only in a cycle where iq_valid_i and iq_ready_o are both high.
module dispatcher
    import dispatcher_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rdy_i,
    input  logic             iq_valid_i,
    output logic             iq_ready_o,
    input  logic [OP_W-1:0]  iq_op_i,
    input  logic [4:0]       iq_rd_i,
    input  logic [4:0]       iq_rs1_i,
    input  logic [4:0]       iq_rs2_i,
    input  logic [XLEN-1:0]  iq_imm_i,
    input  logic [XLEN-1:0]  iq_pc_i,
    input  logic             iq_use_rs1_i,
    input  logic             iq_use_rs2_i,
    input  logic             iq_is_ls_i,
    input  logic             iq_serialize_i,
    input  logic             rob_full_i,
    input  logic             rob_empty_i,
    input  logic [TAG_W-1:0] rob_free_tag_i,
    output logic             rob_alloc_o,
    output logic [OP_W-1:0]  rob_op_o,
    output logic [4:0]       rob_rd_o,
    output logic [XLEN-1:0]  rob_pc_o,
    output logic [4:0]       rf_rs1_o,
    output logic [4:0]       rf_rs2_o,
    input  logic [TAG_W-1:0] rf_Qi_i,
    input  logic [TAG_W-1:0] rf_Qj_i,
    input  logic [XLEN-1:0]  rf_Vi_i,
    input  logic [XLEN-1:0]  rf_Vj_i,
    output logic             rf_dispatch_enable_o,
    output logic [4:0]       rf_dispatch_name_o,
    output logic [TAG_W-1:0] rf_dispatch_rename_o,
    output logic [TAG_W-1:0] rob_q1_tag_o,
    output logic [TAG_W-1:0] rob_q2_tag_o,
    input  logic             rob_q1_ready_i,
    input  logic             rob_q2_ready_i,
    input  logic [XLEN-1:0]  rob_q1_data_i,
    input  logic [XLEN-1:0]  rob_q2_data_i,
    input  logic             commit_valid_i,
    input  logic [4:0]       commit_dest_i,
    input  logic             alu_cdb_valid_i,
    input  logic             lsb_cdb_valid_i,
    input  logic [TAG_W-1:0] alu_cdb_tag_i,
    input  logic [TAG_W-1:0] lsb_cdb_tag_i,
    input  logic [XLEN-1:0]  alu_cdb_data_i,
    input  logic [XLEN-1:0]  lsb_cdb_data_i,
    input  logic             rs_full_i,
    input  logic             lsb_full_i,
    output logic             rs_issue_o,
    output logic             lsb_issue_o,
    output logic [OP_W-1:0]  is_op_o,
    output logic [TAG_W-1:0] is_Qi_o,
    output logic [TAG_W-1:0] is_Qj_o,
    output logic [TAG_W-1:0] is_dest_o,
    output logic [XLEN-1:0]  is_Vi_o,
    output logic [XLEN-1:0]  is_Vj_o,
    output logic [XLEN-1:0]  is_imm_o,
    output logic [XLEN-1:0]  is_pc_o,
    input  logic             wrong_commit_i,
    output logic             state_o
);
    disp_state_e      state_q, state_d;
    issue_t           issue_q, issue_d;
    logic             issue_vld_q, issue_vld_d;
    logic             tgt_full, commit_hazard, serial_wait, fire;
    logic [TAG_W-1:0] op1_q, op2_q;
    logic [XLEN-1:0]  op1_v, op2_v;

    assign tgt_full = iq_is_ls_i ? lsb_full_i : rs_full_i;
    // A commit to the same rd this cycle would overwrite the new rename in the RF.
    assign commit_hazard = commit_valid_i && (commit_dest_i == iq_rd_i) && (iq_rd_i != 5'd0);
    assign serial_wait   = iq_serialize_i && !rob_empty_i;
    assign fire = rdy_i && !rst_i && iq_valid_i && !rob_full_i && !tgt_full &&
                  !wrong_commit_i && !commit_hazard && !serial_wait;

    dispatcher_operand_resolve u_op1 (
        .use_i      (iq_use_rs1_i),    .rs_i       (iq_rs1_i),
        .rf_q_i     (rf_Qi_i),         .rf_v_i     (rf_Vi_i),
        .alu_valid_i(alu_cdb_valid_i), .alu_tag_i  (alu_cdb_tag_i), .alu_data_i(alu_cdb_data_i),
        .lsb_valid_i(lsb_cdb_valid_i), .lsb_tag_i  (lsb_cdb_tag_i), .lsb_data_i(lsb_cdb_data_i),
        .rob_ready_i(rob_q1_ready_i),  .rob_data_i (rob_q1_data_i),
        .q_o        (op1_q),           .v_o        (op1_v)
    );

    dispatcher_operand_resolve u_op2 (
        .use_i      (iq_use_rs2_i),    .rs_i       (iq_rs2_i),
        .rf_q_i     (rf_Qj_i),         .rf_v_i     (rf_Vj_i),
        .alu_valid_i(alu_cdb_valid_i), .alu_tag_i  (alu_cdb_tag_i), .alu_data_i(alu_cdb_data_i),
        .lsb_valid_i(lsb_cdb_valid_i), .lsb_tag_i  (lsb_cdb_tag_i), .lsb_data_i(lsb_cdb_data_i),
        .rob_ready_i(rob_q2_ready_i),  .rob_data_i (rob_q2_data_i),
        .q_o        (op2_q),           .v_o        (op2_v)
    );

    always_comb begin
        state_d     = state_q;
        issue_d     = issue_q;
        issue_vld_d = issue_vld_q;
        if (rdy_i) begin
            case (state_q)
                ST_RUN:   if (!wrong_commit_i && iq_valid_i && serial_wait) state_d = ST_DRAIN;
                ST_DRAIN: if (wrong_commit_i || rob_empty_i) state_d = ST_RUN;
                default:  state_d = ST_RUN;
            endcase
            issue_vld_d = fire;
            if (fire) begin
                issue_d = '{is_ls: iq_is_ls_i, op: iq_op_i, qi: op1_q, qj: op2_q,
                            dest: rob_free_tag_i, vi: op1_v, vj: op2_v,
                            imm: iq_imm_i, pc: iq_pc_i};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            issue_vld_q <= 1'b0;
            issue_q     <= '{op: OP_NOP, default: '0};
        end else begin
            state_q     <= state_d;
            issue_vld_q <= issue_vld_d;
            issue_q     <= issue_d;
        end
    end

    assign state_o              = (state_q == ST_DRAIN);
    assign iq_ready_o           = fire;
    assign rob_alloc_o          = fire;
    assign rob_op_o             = fire ? iq_op_i : OP_NOP;
    assign rob_rd_o             = fire ? iq_rd_i : 5'd0;
    assign rob_pc_o             = fire ? iq_pc_i : '0;
    assign rf_rs1_o             = iq_rs1_i;
    assign rf_rs2_o             = iq_rs2_i;
    assign rob_q1_tag_o         = rf_Qi_i;
    assign rob_q2_tag_o         = rf_Qj_i;
    assign rf_dispatch_enable_o = fire;
    assign rf_dispatch_name_o   = fire ? iq_rd_i : 5'd0;
    assign rf_dispatch_rename_o = fire ? rob_free_tag_i : NO_DEP;

    // Strobes are suppressed while frozen so a held entry issues once rdy returns.
    assign rs_issue_o  = issue_vld_q && rdy_i && !issue_q.is_ls;
    assign lsb_issue_o = issue_vld_q && rdy_i && issue_q.is_ls;
    assign is_op_o     = issue_q.op;
    assign is_dest_o   = issue_q.dest;
    assign is_imm_o    = issue_q.imm;
    assign is_pc_o     = issue_q.pc;

    always_comb begin
        is_Qi_o = issue_q.qi;
        is_Vi_o = issue_q.vi;
        is_Qj_o = issue_q.qj;
        is_Vj_o = issue_q.vj;
        if (issue_vld_q) begin
            if (cdb_hit(alu_cdb_valid_i, alu_cdb_tag_i, issue_q.qi)) begin
                is_Qi_o = NO_DEP;
                is_Vi_o = alu_cdb_data_i;
            end else if (cdb_hit(lsb_cdb_valid_i, lsb_cdb_tag_i, issue_q.qi)) begin
                is_Qi_o = NO_DEP;
                is_Vi_o = lsb_cdb_data_i;
            end
            if (cdb_hit(alu_cdb_valid_i, alu_cdb_tag_i, issue_q.qj)) begin
                is_Qj_o = NO_DEP;
                is_Vj_o = alu_cdb_data_i;
            end else if (cdb_hit(lsb_cdb_valid_i, lsb_cdb_tag_i, issue_q.qj)) begin
                is_Qj_o = NO_DEP;
                is_Vj_o = lsb_cdb_data_i;
            end
        end
    end
endmodule

// File: tb/tb_dispatcher.sv
// Directed scenarios followed by random traffic, each cycle compared against a
// cycle-level reference model of the dispatch rules.
module tb_dispatcher;
    import dispatcher_pkg::*;

    logic clk = 1'b0, rst, rdy;
    logic iq_valid, iq_ready, iq_use_rs1, iq_use_rs2, iq_is_ls, iq_serialize;
    logic [5:0] iq_op;
    logic [4:0] iq_rd, iq_rs1, iq_rs2;
    logic [31:0] iq_imm, iq_pc;
    logic rob_full, rob_empty, rob_alloc;
    logic [4:0] rob_free_tag, rob_rd;
    logic [5:0] rob_op;
    logic [31:0] rob_pc;
    logic [4:0] rf_rs1, rf_rs2, rf_Qi, rf_Qj, rf_dispatch_name, rf_dispatch_rename;
    logic [31:0] rf_Vi, rf_Vj;
    logic rf_dispatch_enable;
    logic [4:0] rob_q1_tag, rob_q2_tag;
    logic rob_q1_ready, rob_q2_ready;
    logic [31:0] rob_q1_data, rob_q2_data;
    logic commit_valid;
    logic [4:0] commit_dest;
    logic alu_cdb_valid, lsb_cdb_valid;
    logic [4:0] alu_cdb_tag, lsb_cdb_tag;
    logic [31:0] alu_cdb_data, lsb_cdb_data;
    logic rs_full, lsb_full, rs_issue, lsb_issue, wrong_commit, state;
    logic [5:0] is_op;
    logic [4:0] is_Qi, is_Qj, is_dest;
    logic [31:0] is_Vi, is_Vj, is_imm, is_pc;

    always #5 clk = ~clk;

    dispatcher dut (
        .clk_i(clk), .rst_i(rst), .rdy_i(rdy),
        .iq_valid_i(iq_valid), .iq_ready_o(iq_ready), .iq_op_i(iq_op), .iq_rd_i(iq_rd),
        .iq_rs1_i(iq_rs1), .iq_rs2_i(iq_rs2), .iq_imm_i(iq_imm), .iq_pc_i(iq_pc),
        .iq_use_rs1_i(iq_use_rs1), .iq_use_rs2_i(iq_use_rs2), .iq_is_ls_i(iq_is_ls),
        .iq_serialize_i(iq_serialize),
        .rob_full_i(rob_full), .rob_empty_i(rob_empty), .rob_free_tag_i(rob_free_tag),
        .rob_alloc_o(rob_alloc), .rob_op_o(rob_op), .rob_rd_o(rob_rd), .rob_pc_o(rob_pc),
        .rf_rs1_o(rf_rs1), .rf_rs2_o(rf_rs2), .rf_Qi_i(rf_Qi), .rf_Qj_i(rf_Qj),
        .rf_Vi_i(rf_Vi), .rf_Vj_i(rf_Vj), .rf_dispatch_enable_o(rf_dispatch_enable),
        .rf_dispatch_name_o(rf_dispatch_name), .rf_dispatch_rename_o(rf_dispatch_rename),
        .rob_q1_tag_o(rob_q1_tag), .rob_q2_tag_o(rob_q2_tag),
        .rob_q1_ready_i(rob_q1_ready), .rob_q2_ready_i(rob_q2_ready),
        .rob_q1_data_i(rob_q1_data), .rob_q2_data_i(rob_q2_data),
        .commit_valid_i(commit_valid), .commit_dest_i(commit_dest),
        .alu_cdb_valid_i(alu_cdb_valid), .lsb_cdb_valid_i(lsb_cdb_valid),
        .alu_cdb_tag_i(alu_cdb_tag), .lsb_cdb_tag_i(lsb_cdb_tag),
        .alu_cdb_data_i(alu_cdb_data), .lsb_cdb_data_i(lsb_cdb_data),
        .rs_full_i(rs_full), .lsb_full_i(lsb_full), .rs_issue_o(rs_issue), .lsb_issue_o(lsb_issue),
        .is_op_o(is_op), .is_Qi_o(is_Qi), .is_Qj_o(is_Qj), .is_dest_o(is_dest),
        .is_Vi_o(is_Vi), .is_Vj_o(is_Vj), .is_imm_o(is_imm), .is_pc_o(is_pc),
        .wrong_commit_i(wrong_commit), .state_o(state)
    );

    typedef struct packed {
        logic ls; logic [5:0] op; logic [4:0] qi, qj, dest;
        logic [31:0] vi, vj, imm, pc;
    } tb_iss_t;
    localparam int ISS_W = $bits(tb_iss_t);

    logic [ISS_W-1:0] exp_q[$];
    logic    m_drain = 1'b0;
    logic    nx_fire;
    tb_iss_t nx_iss;
    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Operand seen by the instruction: {tag, value}; tag 0 means value is final.
    function automatic logic [36:0] ref_operand(input logic use_op, input logic [4:0] rs,
        input logic [4:0] rf_tag, input logic [31:0] rf_val,
        input logic rob_rdy, input logic [31:0] rob_val);
        if (!use_op || rs == 5'd0) return {5'd0, 32'd0};
        if (rf_tag == 5'd0) return {5'd0, rf_val};
        if (alu_cdb_valid && alu_cdb_tag == rf_tag) return {5'd0, alu_cdb_data};
        if (lsb_cdb_valid && lsb_cdb_tag == rf_tag) return {5'd0, lsb_cdb_data};
        if (rob_rdy) return {5'd0, rob_val};
        return {rf_tag, 32'd0};
    endfunction

    task automatic idle();
        rdy = 1; iq_valid = 0; iq_op = 0; iq_rd = 0; iq_rs1 = 0; iq_rs2 = 0;
        iq_imm = 0; iq_pc = 0; iq_use_rs1 = 0; iq_use_rs2 = 0; iq_is_ls = 0; iq_serialize = 0;
        rob_full = 0; rob_empty = 1; rob_free_tag = 0; rf_Qi = 0; rf_Qj = 0; rf_Vi = 0; rf_Vj = 0;
        rob_q1_ready = 0; rob_q2_ready = 0; rob_q1_data = 0; rob_q2_data = 0;
        commit_valid = 0; commit_dest = 0; alu_cdb_valid = 0; lsb_cdb_valid = 0;
        alu_cdb_tag = 0; lsb_cdb_tag = 0; alu_cdb_data = 0; lsb_cdb_data = 0;
        rs_full = 0; lsb_full = 0; wrong_commit = 0;
    endtask

    task automatic check_model();
        logic stalled, strobe;
        logic [36:0] a, b;
        tb_iss_t p;
        #2;
        stalled = rob_full || (iq_is_ls ? lsb_full : rs_full) || wrong_commit ||
                  (commit_valid && commit_dest == iq_rd && iq_rd != 5'd0) ||
                  (iq_serialize && !rob_empty);
        nx_fire = !rst && rdy && iq_valid && !stalled;
        chk("iq_ready", iq_ready, nx_fire);
        chk("rob_alloc", rob_alloc, nx_fire);
        chk("rf_enable", rf_dispatch_enable, nx_fire);
        chk("state", state, m_drain);
        chk("rf_rs1", rf_rs1, iq_rs1);
        if (nx_fire) begin
            chk("rf_name", rf_dispatch_name, iq_rd);
            chk("rf_rename", rf_dispatch_rename, rob_free_tag);
            chk("rob_op", rob_op, iq_op);
            chk("rob_rd", rob_rd, iq_rd);
            chk("rob_pc", rob_pc, iq_pc);
        end
        a = ref_operand(iq_use_rs1, iq_rs1, rf_Qi, rf_Vi, rob_q1_ready, rob_q1_data);
        b = ref_operand(iq_use_rs2, iq_rs2, rf_Qj, rf_Vj, rob_q2_ready, rob_q2_data);
        nx_iss = '{ls: iq_is_ls, op: iq_op, qi: a[36:32], qj: b[36:32], dest: rob_free_tag,
                   vi: a[31:0], vj: b[31:0], imm: iq_imm, pc: iq_pc};
        strobe = rdy && !rst && exp_q.size() != 0;
        p = (exp_q.size() != 0) ? tb_iss_t'(exp_q[0]) : '0;
        chk("rs_issue", rs_issue, strobe && !p.ls);
        chk("lsb_issue", lsb_issue, strobe && p.ls);
        if (strobe) begin
            if (p.qi != 0 && alu_cdb_valid && alu_cdb_tag == p.qi) begin p.qi = 0; p.vi = alu_cdb_data; end
            else if (p.qi != 0 && lsb_cdb_valid && lsb_cdb_tag == p.qi) begin p.qi = 0; p.vi = lsb_cdb_data; end
            if (p.qj != 0 && alu_cdb_valid && alu_cdb_tag == p.qj) begin p.qj = 0; p.vj = alu_cdb_data; end
            else if (p.qj != 0 && lsb_cdb_valid && lsb_cdb_tag == p.qj) begin p.qj = 0; p.vj = lsb_cdb_data; end
            chk("is_op", is_op, p.op);
            chk("is_Qi", is_Qi, p.qi);
            chk("is_Qj", is_Qj, p.qj);
            chk("is_Vi", is_Vi, p.vi);
            chk("is_Vj", is_Vj, p.vj);
            chk("is_imm", is_imm, p.imm);
            chk("is_pc", is_pc, p.pc);
            chk("is_dest", is_dest, p.dest);
        end
    endtask

    task automatic edge_upd();
        @(posedge clk);
        if (rst) begin
            m_drain = 1'b0;
            exp_q.delete();
        end else if (rdy) begin
            exp_q.delete();
            if (nx_fire) exp_q.push_back(ISS_W'(nx_iss));
            if (wrong_commit) m_drain = 1'b0;
            else if (m_drain) m_drain = !rob_empty;
            else if (iq_valid && iq_serialize && !rob_empty) m_drain = 1'b1;
        end
        #1;
    endtask

    task automatic tick();
        check_model();
        edge_upd();
    endtask

    task automatic set_insn(input logic [5:0] op, input logic [4:0] rd, rs1, rs2,
                            input logic u1, u2, ls, input logic [31:0] imm, pc,
                            input logic [4:0] tag);
        iq_valid = 1; iq_op = op; iq_rd = rd; iq_rs1 = rs1; iq_rs2 = rs2;
        iq_use_rs1 = u1; iq_use_rs2 = u2; iq_is_ls = ls; iq_imm = imm; iq_pc = pc;
        rob_free_tag = tag;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk); #1;
        tick();
        rst = 0;
        // Idle after reset.
        check_model();
        chk("rst_iq_ready", iq_ready, 1'b0);
        chk("rst_rs_issue", rs_issue, 1'b0);
        chk("rst_is_Vi", is_Vi, 32'd0);
        chk("rst_is_dest", is_dest, 5'd0);
        edge_upd();

        // addi x5,x0,7 with free tag 3.
        set_insn(OP_ADDI, 5'd5, 5'd0, 5'd0, 1, 0, 0, 32'd7, 32'h100, 5'd3);
        check_model();
        chk("addi_name", rf_dispatch_name, 5'd5);
        chk("addi_rename", rf_dispatch_rename, 5'd3);
        edge_upd();
        // add x6,x5,x5 back to back: RF shows A's rename 3; ALU CDB broadcasts 3 next cycle.
        set_insn(OP_ADD, 5'd6, 5'd5, 5'd5, 1, 1, 0, 32'd0, 32'h104, 5'd4);
        rf_Qi = 5'd3; rf_Qj = 5'd3;
        check_model();
        chk("addi_rs_issue", rs_issue, 1'b1);
        chk("addi_imm", is_imm, 32'd7);
        chk("addi_dest", is_dest, 5'd3);
        chk("addi_Vi", is_Vi, 32'd0);
        edge_upd();
        idle();
        alu_cdb_valid = 1; alu_cdb_tag = 5'd3; alu_cdb_data = 32'd42;
        check_model();
        chk("wake_Qi", is_Qi, 5'd0);
        chk("wake_Vj", is_Vj, 32'd42);
        edge_upd();

        // RF says wait on 4 but the ROB already holds the value.
        idle();
        set_insn(OP_ADD, 5'd7, 5'd1, 5'd0, 1, 1, 0, 32'd0, 32'h108, 5'd5);
        rf_Qi = 5'd4; rob_q1_ready = 1; rob_q1_data = 32'd9;
        tick();
        idle();
        check_model();
        chk("robfwd_Qi", is_Qi, 5'd0);
        chk("robfwd_Vi", is_Vi, 32'd9);
        edge_upd();

        // Same-cycle commit to rd stalls one cycle.
        set_insn(OP_ADDI, 5'd5, 5'd0, 5'd0, 1, 0, 0, 32'd1, 32'h10c, 5'd6);
        commit_valid = 1; commit_dest = 5'd5;
        check_model();
        chk("commit_stall", iq_ready, 1'b0);
        edge_upd();
        commit_valid = 0;
        check_model();
        chk("commit_retry", iq_ready, 1'b1);
        edge_upd();

        // Fence waits for an empty ROB.
        idle();
        set_insn(OP_FENCE, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'd0, 32'h110, 5'd7);
        iq_serialize = 1; rob_empty = 0;
        for (int i = 0; i < 3; i++) tick();
        check_model();
        chk("fence_drain", state, 1'b1);
        edge_upd();
        rob_empty = 1;
        check_model();
        chk("fence_fire", iq_ready, 1'b1);
        edge_upd();

        // Load blocked by a flush in its fire cycle.
        idle();
        set_insn(OP_LW, 5'd8, 5'd2, 5'd0, 1, 0, 1, 32'd4, 32'h114, 5'd8);
        wrong_commit = 1;
        tick();
        idle();
        check_model();
        chk("flush_no_lsb", lsb_issue, 1'b0);
        edge_upd();

        // Freeze with an issue pending.
        set_insn(OP_LW, 5'd9, 5'd2, 5'd0, 1, 0, 1, 32'd8, 32'h118, 5'd9);
        tick();
        idle();
        rdy = 0;
        tick();
        tick();
        rdy = 1;
        check_model();
        chk("thaw_lsb_issue", lsb_issue, 1'b1);
        edge_upd();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            rdy          = ($urandom_range(0, 9) != 0);
            iq_valid     = ($urandom_range(0, 3) != 0);
            iq_op        = 6'($urandom_range(0, 5));
            iq_rd        = 5'($urandom_range(0, 7));
            iq_rs1       = 5'($urandom_range(0, 7));
            iq_rs2       = 5'($urandom_range(0, 7));
            iq_use_rs1   = 1'($urandom);
            iq_use_rs2   = 1'($urandom);
            iq_is_ls     = 1'($urandom);
            iq_serialize = ($urandom_range(0, 15) == 0);
            iq_imm       = $urandom;
            iq_pc        = $urandom;
            rob_full     = ($urandom_range(0, 9) == 0);
            rob_empty    = 1'($urandom);
            rob_free_tag = 5'($urandom_range(1, 31));
            rf_Qi        = 5'($urandom_range(0, 3));
            rf_Qj        = 5'($urandom_range(0, 3));
            rf_Vi        = $urandom;
            rf_Vj        = $urandom;
            rob_q1_ready = ($urandom_range(0, 3) == 0);
            rob_q2_ready = ($urandom_range(0, 3) == 0);
            rob_q1_data  = $urandom;
            rob_q2_data  = $urandom;
            commit_valid = ($urandom_range(0, 2) == 0);
            commit_dest  = 5'($urandom_range(0, 7));
            alu_cdb_valid = 1'($urandom);
            lsb_cdb_valid = 1'($urandom);
            alu_cdb_tag  = 5'($urandom_range(1, 3));
            lsb_cdb_tag  = 5'($urandom_range(1, 3));
            alu_cdb_data = $urandom;
            lsb_cdb_data = $urandom;
            rs_full      = ($urandom_range(0, 6) == 0);
            lsb_full     = ($urandom_range(0, 6) == 0);
            wrong_commit = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
